// File: rtl/rgb_fade_sequencer.sv
// RGB LED sequencer: command-driven jump/fade with glitch-free 8-bit PWM.
// Duty updates only at PWM period boundaries.
module rgb_fade_sequencer #(
  parameter int unsigned PRESCALE = 188,
  parameter int unsigned FADE_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_red,
  input  logic [7:0] cmd_green,
  input  logic [7:0] cmd_blue,
  input  logic       cmd_fade,
  input  logic [7:0] cmd_hold,
  output logic       busy,
  output logic       red_pwm,
  output logic       green_pwm,
  output logic       blue_pwm,
  output logic       led_en
);

  typedef enum logic [1:0] {
    IDLE,
    FADE,
    HOLD
  } state_t;

  localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
  localparam logic [7:0]  STEP_LAST = 8'(FADE_DIV - 1);

  state_t      state, state_nx;
  logic [15:0] presc;
  logic [7:0]  pwm_cnt;
  logic        tick, period_end;
  logic [7:0]  cur_r, cur_g, cur_b;
  logic [7:0]  act_r, act_g, act_b;
  logic [7:0]  tgt_r, tgt_g, tgt_b;
  logic [7:0]  hold, hold_cnt, step_cnt;
  logic        at_tgt;
  logic        accept, do_step, step_inc;
  logic        hold_clr, hold_inc;

  function automatic logic [7:0] nudge(
    input logic [7:0] c,
    input logic [7:0] t
  );
    if (c < t)      return c + 8'd1;
    else if (c > t) return c - 8'd1;
    else            return c;
  endfunction

  assign tick       = (presc == PRE_LAST);
  assign period_end = tick && (pwm_cnt == 8'hff);
  assign at_tgt     = (cur_r == tgt_r) &&
                      (cur_g == tgt_g) &&
                      (cur_b == tgt_b);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    do_step  = 1'b0;
    step_inc = 1'b0;
    hold_clr = 1'b0;
    hold_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept   = 1'b1;
          state_nx = cmd_fade ? FADE : HOLD;
        end
      end
      FADE: begin
        if (at_tgt) begin
          hold_clr = 1'b1;
          state_nx = HOLD;
        end else if (period_end) begin
          if (step_cnt == STEP_LAST) do_step = 1'b1;
          else                       step_inc = 1'b1;
        end
      end
      HOLD: begin
        if (hold_cnt == hold) state_nx = IDLE;
        else if (period_end)  hold_inc = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      presc     <= '0;
      pwm_cnt   <= '0;
      act_r     <= '0;
      act_g     <= '0;
      act_b     <= '0;
      red_pwm   <= 1'b0;
      green_pwm <= 1'b0;
      blue_pwm  <= 1'b0;
      led_en    <= 1'b0;
    end else begin
      state     <= state_nx;
      cmd_ready <= (state_nx == IDLE);
      busy      <= (state_nx != IDLE);
      presc     <= tick ? '0 : presc + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      // act_* sees the pre-update cur_* on a coincident edge
      if (period_end) begin
        act_r <= cur_r;
        act_g <= cur_g;
        act_b <= cur_b;
      end
      red_pwm   <= (pwm_cnt < act_r);
      green_pwm <= (pwm_cnt < act_g);
      blue_pwm  <= (pwm_cnt < act_b);
      led_en    <= |{act_r, act_g, act_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_r    <= '0;
      cur_g    <= '0;
      cur_b    <= '0;
      tgt_r    <= '0;
      tgt_g    <= '0;
      tgt_b    <= '0;
      hold     <= '0;
      hold_cnt <= '0;
      step_cnt <= '0;
    end else begin
      if (accept) begin
        tgt_r    <= cmd_red;
        tgt_g    <= cmd_green;
        tgt_b    <= cmd_blue;
        hold     <= cmd_hold;
        hold_cnt <= '0;
        step_cnt <= '0;
        if (!cmd_fade) begin
          cur_r <= cmd_red;
          cur_g <= cmd_green;
          cur_b <= cmd_blue;
        end
      end
      if (do_step) begin
        cur_r    <= nudge(cur_r, tgt_r);
        cur_g    <= nudge(cur_g, tgt_g);
        cur_b    <= nudge(cur_b, tgt_b);
        step_cnt <= '0;
      end else if (step_inc) begin
        step_cnt <= step_cnt + 8'd1;
      end
      if (hold_clr)      hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + 8'd1;
    end
  end

endmodule
